// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides clk down to the pixel rate, runs the
// h/v raster counters and registers blanked colour plus Hsync/Vsync to the pins.
module vga_sync_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_tick,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       pix_req,
   output logic       frame_start,
   input  logic [2:0] rgb_in,
   output logic       vga_R,
   output logic       vga_G,
   output logic       vga_B,
   output logic       Hsync,
   output logic       Vsync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic       SYNC_ACT = (SYNC_POL != 0);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             hs_on;
   logic             vs_on;

   assign pix_x       = h_cnt;
   assign pix_y       = v_cnt;
   assign pix_req     = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
   assign hs_on       = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
   assign vs_on       = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
   assign frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);

   // Output stage uses pre-increment counts, so pins lag pix_x/pix_y by one pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         pix_tick <= 1'b0;
         h_cnt    <= '0;
         v_cnt    <= '0;
         vga_R    <= 1'b0;
         vga_G    <= 1'b0;
         vga_B    <= 1'b0;
         Hsync    <= ~SYNC_ACT;
         Vsync    <= ~SYNC_ACT;
      end else begin
         div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         pix_tick <= (div_cnt == DIV_LAST);
         if (pix_tick) begin
            {vga_R, vga_G, vga_B} <= pix_req ? rgb_in : 3'b000;
            Hsync <= hs_on ? SYNC_ACT : ~SYNC_ACT;
            Vsync <= vs_on ? SYNC_ACT : ~SYNC_ACT;
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 Hz timing from the 100 MHz board clock.
- Presents the current pixel coordinate to an upstream pattern/pixel source and accepts its 3-bit colour.
- Drives the 1-bit vga_R/vga_G/vga_B, Hsync and Vsync pins, blanking colour outside the active area.
- Sits directly between pixel-generation logic and the VGA connector inside the top-level demo.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range ≥1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of Hsync/Vsync (0 = active-low).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- pix_tick  out  1  one-clk strobe; counters advance and the output stage updates on this strobe.
- pix_x  out  10  current horizontal count, h_cnt.
- pix_y  out  10  current vertical count, v_cnt.
- pix_req  out  1  high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- frame_start  out  1  one-clk pulse at the start of each frame.
- rgb_in  in  3  colour {R,G,B} for (pix_x, pix_y); sampled on pix_tick.
- vga_R, vga_G, vga_B  out  1 each  registered colour to the pins.
- Hsync  out  1  registered horizontal sync.
- Vsync  out  1  registered vertical sync.

Behaviour:
- Interface: single clock, clk. Reset rst is synchronous and active-high. Every register samples rst only on a rising edge of clk.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024 because the counters are 10 bits.
- Reset values: div_cnt=0, h_cnt=0, v_cnt=0, pix_tick=0, frame_start=0, vga_R/G/B=0, Hsync=Vsync=~SYNC_POL (inactive).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick is registered, high for exactly one clk when div_cnt == CLK_DIV-1.
  - The first pix_tick occurs CLK_DIV clks after rst deasserts.
  - With CLK_DIV=1, pix_tick is permanently 1 after the first post-reset clk.
- Counters, updated on pix_tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps.
  - No other updates occur.
- pix_x, pix_y, pix_req are driven directly from the counters. They are stable between ticks.
- Upstream contract: rgb_in must be valid for the current (pix_x, pix_y) at every pix_tick. Zero-latency source.
- Output stage, registered on pix_tick, using the pre-increment counter values:
  - vga_{R,G,B} <= pix_req ? rgb_in : 3'b000.
  - Hsync <= SYNC_POL when H_ACTIVE+H_FP ≤ h_cnt ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751); otherwise ~SYNC_POL.
  - Vsync <= SYNC_POL when V_ACTIVE+V_FP ≤ v_cnt ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491); otherwise ~SYNC_POL.
  - Colour and syncs therefore lag the counters by exactly one pixel period, consistently with each other.
- frame_start = pix_tick && h_cnt==0 && v_cnt==0, combinational. It fires once per frame, including the first tick after reset.
- Periods at defaults:
  - Line: 3200 clks.
  - Hsync low: 384 clks.
  - Frame: 1,680,000 clks.
  - Vsync low: 6400 clks.
- Reset mid-frame: all registers return to reset values on the next clk edge. rgb_in is ignored while rst=1. The sequence restarts exactly as from power-up.
- rgb_in changes between ticks are ignored.

Test Plan:
- Reset release, defaults:
  - First pix_tick at clk 4 after rst falls; frame_start high in the same cycle.
  - First tick sees h_cnt=0, v_cnt=0; pix_x=1 after it.
- Horizontal timing:
  - Hsync falls 657 ticks after line start (output lag 1).
  - Hsync stays low exactly 384 clks.
  - Consecutive Hsync falling edges are 3200 clks apart.
- Vertical timing:
  - Vsync low exactly 6400 clks.
  - Vsync falling edges 1,680,000 clks apart.
  - frame_start period 1,680,000 clks.
- Blanking, rgb_in held at 3'b111:
  - vga_RGB=111 for 640 ticks per visible line, 000 for 160 ticks.
  - All 000 during lines 480..524.
- Mid-frame reset: assert rst for 1 clk at v_cnt=200, h_cnt=300.
  - Next edge: counters=0, RGB=000, Hsync=Vsync=1.
  - Timing then matches the reset-release scenario.
- CLK_DIV=1, SYNC_POL=1: pix_tick constant high, line=800 clks, Hsync high for 96 clks.
